// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Define RV32M_EN to add the single-cycle multiplier and the iterative divider FSM.
package ex_pkg;
  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic            MemWrite;
    logic            Jump;
    logic            Branch;
    logic            ALUSrc;
    logic            Jalr;
    logic            RType;
    logic [3:0]      ALUControl;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] PCPlus4;
    logic [4:0]      Rs1;
    logic [4:0]      Rs2;
    logic [4:0]      Rd;
  } idex_t;

  typedef struct packed {
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic            MemWrite;
    logic [2:0]      funct3;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] WriteData;
    logic [XLEN-1:0] PCPlus4;
    logic [4:0]      Rd;
  } exmem_t;
endpackage

module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = ex_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  idex_t           inputs,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic            StallM,
  input  logic            FlushM,
  input  logic            FlushE,
  output exmem_t          outputs,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ResultSrcE0,
  output logic            MdBusyE
);

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_result, ex_result;
  logic [4:0]      shamt;
  logic            taken, div_kill;
  exmem_t          ex_pkt;

  always_comb begin
    case (ForwardAE)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = ALUResultM;
      default: fwd_a = inputs.RD1;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = inputs.RD2;
    endcase
  end

  assign src_a = fwd_a;
  assign src_b = inputs.ALUSrc ? inputs.ImmExt : fwd_b;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_result = '0;
    case (inputs.ALUControl)
      ALU_ADD:   alu_result = src_a + src_b;
      ALU_SUB:   alu_result = src_a - src_b;
      ALU_AND:   alu_result = src_a & src_b;
      ALU_OR:    alu_result = src_a | src_b;
      ALU_XOR:   alu_result = src_a ^ src_b;
      ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:   alu_result = src_a << shamt;
      ALU_SRL:   alu_result = src_a >> shamt;
      ALU_SRA:   alu_result = $signed(src_a) >>> shamt;
      ALU_PASSB: alu_result = src_b;
      default:   alu_result = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (inputs.funct3)
      3'b000:  taken = (src_a == src_b);
      3'b001:  taken = (src_a != src_b);
      3'b100:  taken = ($signed(src_a) < $signed(src_b));
      3'b101:  taken = ($signed(src_a) >= $signed(src_b));
      3'b110:  taken = (src_a < src_b);
      3'b111:  taken = (src_a >= src_b);
      default: taken = 1'b0;
    endcase
  end

  // JALR targets are register-relative and must be halfword aligned.
  assign PCSrcE    = inputs.Jump | (inputs.Branch & taken);
  assign PCTargetE = ((inputs.Jalr ? src_a : inputs.PC) + inputs.ImmExt)
                     & ~{{(XLEN-1){1'b0}}, inputs.Jalr};

  assign Rs1E        = inputs.Rs1;
  assign Rs2E        = inputs.Rs2;
  assign RdE         = inputs.Rd;
  assign ResultSrcE0 = inputs.ResultSrc[0];

`ifdef RV32M_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  localparam int CW = $clog2(XLEN + 1);

  div_state_t        state, state_next;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   quot, rem, divisor, a_mag, b_mag, div_result, mul_result;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic [2*XLEN+1:0] mul_a, mul_b, product;
  logic              md_op, mul_op, div_op, div_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, neg_q, neg_r, unused_md;

  assign md_op  = inputs.RType & (inputs.funct7 == 7'b0000001);
  assign mul_op = md_op & ~inputs.funct3[2];
  assign div_op = md_op & inputs.funct3[2];

  // MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed.
  assign mul_a = {{(XLEN+2){(inputs.funct3[1:0] != 2'b11) & src_a[XLEN-1]}}, src_a};
  assign mul_b = {{(XLEN+2){(inputs.funct3[1:0] == 2'b01) & src_b[XLEN-1]}}, src_b};
  assign product    = mul_a * mul_b;
  assign mul_result = (inputs.funct3[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  assign unused_md  = ^product[2*XLEN+1:2*XLEN];

  assign div_signed = ~inputs.funct3[0];
  assign a_neg      = div_signed & src_a[XLEN-1];
  assign b_neg      = div_signed & src_b[XLEN-1];
  assign a_mag      = a_neg ? -src_a : src_a;
  assign b_mag      = b_neg ? -src_b : src_b;
  assign div_zero   = (src_b == '0);
  assign div_ovf    = div_signed & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (src_b == '1);
  assign rem_shift  = {rem, quot[XLEN-1]};
  assign rem_diff   = rem_shift - {1'b0, divisor};
  assign div_result = inputs.funct3[1] ? (neg_r ? -rem : rem) : (neg_q ? -quot : quot);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The divide op stays in EX until DONE; any earlier cycle sends a bubble to MEM.
  always_comb begin
    state_next = state;
    MdBusyE    = div_op & (state != DONE) & ~FlushE;
    div_kill   = div_op & ~((state == DONE) & ~FlushE);
    if (FlushE) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (div_op) state_next = (div_zero | div_ovf) ? DONE : BUSY;
        BUSY:    if (cnt == CW'(1)) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Special cases preload their final answer so DONE needs no extra correction.
  always_ff @(posedge clk) begin
    if (reset) begin
      quot <= '0; rem <= '0; divisor <= '0; cnt <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
    end else if (state == IDLE && div_op && !FlushE) begin
      cnt     <= CW'(XLEN);
      divisor <= b_mag;
      rem     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      if (div_zero) begin
        quot <= '1;
        rem  <= src_a;
      end else if (div_ovf) begin
        quot <= src_a;
      end else begin
        quot  <= a_mag;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
      if (!rem_diff[XLEN]) begin
        rem  <= rem_diff[XLEN-1:0];
        quot <= {quot[XLEN-2:0], 1'b1};
      end else begin
        rem  <= rem_shift[XLEN-1:0];
        quot <= {quot[XLEN-2:0], 1'b0};
      end
    end
  end

  assign ex_result = mul_op ? mul_result : (div_op ? div_result : alu_result);
`else
  logic unused_md;
  assign unused_md = ^{inputs.RType, inputs.funct7};
  assign MdBusyE   = 1'b0;
  assign div_kill  = 1'b0;
  assign ex_result = alu_result;
`endif

  always_comb begin
    ex_pkt           = '0;
    ex_pkt.RegWrite  = inputs.RegWrite;
    ex_pkt.ResultSrc = inputs.ResultSrc;
    ex_pkt.MemWrite  = inputs.MemWrite;
    ex_pkt.funct3    = inputs.funct3;
    ex_pkt.ALUResult = ex_result;
    ex_pkt.WriteData = fwd_b;
    ex_pkt.PCPlus4   = inputs.PCPlus4;
    ex_pkt.Rd        = inputs.Rd;
  end

  always_ff @(posedge clk) begin
    if (reset || FlushM)   outputs <= '0;
    else if (!StallM)      outputs <= div_kill ? '0 : ex_pkt;
  end

endmodule
